// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state type and default widths for the Fibonacci generator/checker pair
package fib_pkg;

    localparam int FIB_DATA_W = 4;
    localparam int FIB_CNT_W  = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TRACK = 2'd2
    } fib_state_t;

endpackage

// File: rtl/fib_sat_counter.sv
// rtl/fib_sat_counter.sv - saturating up-counter with synchronous clear
module fib_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fibonacci_checker.sv
// rtl/fibonacci_checker.sv - locks onto a Fibonacci stream and flags samples that break it
// Optional FIB_CHECK_SEED_EN: seeds must be 1 then 1, otherwise they are rejected.
module fibonacci_checker
    import fib_pkg::*;
#(
    parameter int DATA_W = FIB_DATA_W,
    parameter int CNT_W  = FIB_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] expected,
    output logic              locked,
    output logic              error,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  err_count
);

`ifdef FIB_CHECK_SEED_EN
    localparam logic [DATA_W-1:0] SEED_VAL = DATA_W'(1);
`endif

    fib_state_t        state_q, state_d;
    logic [DATA_W-1:0] prev1_q, prev1_d;
    logic [DATA_W-1:0] prev2_q, prev2_d;
    logic [DATA_W-1:0] sum_q;
    logic              accept, reject;

    // Carry out is dropped on purpose: a wrapped sum is still a legal successor.
    assign sum_q = prev1_q + prev2_q;

    always_comb begin
        state_d = state_q;
        prev1_d = prev1_q;
        prev2_d = prev2_q;
        accept  = 1'b0;
        reject  = 1'b0;
        if (din_valid) begin
            case (state_q)
                EMPTY: begin
`ifdef FIB_CHECK_SEED_EN
                    if (din == SEED_VAL) begin
                        prev1_d = din;
                        state_d = ONE;
                    end else begin
                        reject = 1'b1;
                    end
`else
                    prev1_d = din;
                    state_d = ONE;
`endif
                end
                ONE: begin
`ifdef FIB_CHECK_SEED_EN
                    if (din == SEED_VAL) begin
                        prev2_d = prev1_q;
                        prev1_d = din;
                        state_d = TRACK;
                    end else begin
                        reject  = 1'b1;
                        state_d = EMPTY;
                    end
`else
                    prev2_d = prev1_q;
                    prev1_d = din;
                    state_d = TRACK;
`endif
                end
                TRACK: begin
                    prev1_d = din;
                    if (din == sum_q) begin
                        prev2_d = prev1_q;
                        accept  = 1'b1;
                    end else begin
                        // The offending sample becomes the first seed of a fresh lock.
                        reject  = 1'b1;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            prev1_q  <= '0;
            prev2_q  <= '0;
            expected <= '0;
            error    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev1_q  <= prev1_d;
            prev2_q  <= prev2_d;
            expected <= (state_d == TRACK) ? DATA_W'(prev1_d + prev2_d) : '0;
            error    <= reject;
        end
    end

    assign locked = (state_q == TRACK);

    fib_sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (accept),
        .count (match_count)
    );

    fib_sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (reject),
        .count (err_count)
    );

endmodule
